// File: rtl/branch_predictor.sv
// Fetch-side predictor: 2-bit BHT, direct-mapped BTB and circular RAS, trained by execute resolves.
// Prediction and flush are registered (1 cycle); no backpressure, one fetch and one resolve accepted per cycle.
module branch_predictor #(
    parameter int PC_W      = 32,
    parameter int IDX_W     = 6,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             res_valid,
    input  logic [PC_W-1:0]  res_pc,
    input  logic [1:0]       res_type,
    input  logic             res_is_call,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    input  logic             res_pred_taken,
    input  logic [PC_W-1:0]  res_pred_target,
    output logic             flush,
    output logic [PC_W-1:0]  flush_pc,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int RP_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RC_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(RAS_DEPTH - 1);
    localparam logic [RC_W-1:0] RC_FULL = RC_W'(RAS_DEPTH);
    localparam logic [1:0] TY_COND = 2'b01;
    localparam logic [1:0] TY_JUMP = 2'b10;
    localparam logic [1:0] TY_RET  = 2'b11;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  tgt;
        logic [1:0]       typ;
    } btb_t;

    logic [1:0]         r_bht [ENTRIES];
    logic [ENTRIES-1:0] r_btb_vld;
    btb_t               r_btb [ENTRIES];
    logic [PC_W-1:0]    r_ras [RAS_DEPTH];
    logic [RP_W-1:0]    r_ras_ptr;
    logic [RC_W-1:0]    r_ras_cnt;

    logic               r_pred_valid;
    logic               r_pred_taken;
    logic [PC_W-1:0]    r_pred_target;
    logic               r_flush;
    logic [PC_W-1:0]    r_flush_pc;
    logic [CNT_W-1:0]   r_perf_br;
    logic [CNT_W-1:0]   r_perf_mp;

    logic [IDX_W-1:0]   w_f_idx;
    logic [TAG_W-1:0]   w_f_tag;
    logic [IDX_W-1:0]   w_r_idx;
    logic [TAG_W-1:0]   w_r_tag;
    btb_t               w_btb_e;
    logic               w_f_hit;
    logic               w_p_taken;
    logic [PC_W-1:0]    w_p_tgt;
    logic [RP_W-1:0]    w_ras_top;
    logic [RP_W-1:0]    w_ras_nxt;
    logic               w_res_act;
    logic               w_mispred;

    assign w_f_idx   = fetch_pc[IDX_W-1:0];
    assign w_f_tag   = fetch_pc[IDX_W+TAG_W-1:IDX_W];
    assign w_r_idx   = res_pc[IDX_W-1:0];
    assign w_r_tag   = res_pc[IDX_W+TAG_W-1:IDX_W];
    // r_ras_ptr is the next free slot; the top of stack sits just below it
    assign w_ras_top = (r_ras_ptr == '0) ? RP_LAST : r_ras_ptr - RP_W'(1);
    assign w_ras_nxt = (r_ras_ptr == RP_LAST) ? '0 : r_ras_ptr + RP_W'(1);
    assign w_res_act = res_valid && (res_type != 2'b00);
    assign w_mispred = w_res_act && ((res_taken != res_pred_taken) ||
                                     (res_taken && (res_target != res_pred_target)));

    always_comb begin
        w_btb_e   = r_btb[w_f_idx];
        w_f_hit   = r_btb_vld[w_f_idx] && (w_btb_e.tag == w_f_tag);
        w_p_taken = 1'b0;
        w_p_tgt   = fetch_pc + PC_ONE;
        if (w_f_hit) begin
            case (w_btb_e.typ)
                TY_COND: if (r_bht[w_f_idx][1]) begin
                    w_p_taken = 1'b1;
                    w_p_tgt   = w_btb_e.tgt;
                end
                TY_JUMP: begin
                    w_p_taken = 1'b1;
                    w_p_tgt   = w_btb_e.tgt;
                end
                TY_RET: if (r_ras_cnt != '0) begin
                    w_p_taken = 1'b1;
                    w_p_tgt   = r_ras[w_ras_top];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) r_bht[i] <= 2'b01;
            r_btb_vld     <= '0;
            r_ras_ptr     <= '0;
            r_ras_cnt     <= '0;
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_flush       <= 1'b0;
            r_flush_pc    <= '0;
            r_perf_br     <= '0;
            r_perf_mp     <= '0;
        end else begin
            r_pred_valid <= fetch_valid && !w_mispred;
            if (fetch_valid) begin
                r_pred_taken  <= w_p_taken;
                r_pred_target <= w_p_tgt;
            end
            r_flush <= w_mispred;
            if (w_mispred) r_flush_pc <= res_taken ? res_target : res_pc + PC_ONE;
            if (w_res_act) begin
                if (res_type == TY_COND) begin
                    if (res_taken && r_bht[w_r_idx] != 2'b11)
                        r_bht[w_r_idx] <= r_bht[w_r_idx] + 2'b01;
                    else if (!res_taken && r_bht[w_r_idx] != 2'b00)
                        r_bht[w_r_idx] <= r_bht[w_r_idx] - 2'b01;
                end
                if (res_taken) r_btb_vld[w_r_idx] <= 1'b1;
                if (res_is_call) begin
                    r_ras_ptr <= w_ras_nxt;
                    if (r_ras_cnt != RC_FULL) r_ras_cnt <= r_ras_cnt + RC_W'(1);
                end else if (res_type == TY_RET && r_ras_cnt != '0) begin
                    r_ras_ptr <= w_ras_top;
                    r_ras_cnt <= r_ras_cnt - RC_W'(1);
                end
                if (r_perf_br != '1) r_perf_br <= r_perf_br + CNT_W'(1);
                if (w_mispred && r_perf_mp != '1) r_perf_mp <= r_perf_mp + CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset: every read is qualified by r_btb_vld or r_ras_cnt
    always_ff @(posedge clk) begin
        if (!rst && w_res_act && res_taken) begin
            r_btb[w_r_idx] <= '{tag: w_r_tag, tgt: res_target, typ: res_type};
        end
        if (!rst && w_res_act && res_is_call) begin
            r_ras[r_ras_ptr] <= res_pc + PC_ONE;
        end
    end

    assign pred_valid       = r_pred_valid;
    assign pred_taken       = r_pred_taken;
    assign pred_target      = r_pred_target;
    assign flush            = r_flush;
    assign flush_pc         = r_flush_pc;
    assign perf_branches    = r_perf_br;
    assign perf_mispredicts = r_perf_mp;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scenarios then random traffic, every cycle compared against a queue/array reference model.
module tb_branch_predictor;
    localparam int PC_W = 32, IDX_W = 6, TAG_W = 8, RAS_DEPTH = 4, CNT_W = 8;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, fetch_valid, pred_valid, pred_taken;
    logic [PC_W-1:0]  fetch_pc, pred_target;
    logic             res_valid, res_is_call, res_taken, res_pred_taken, flush;
    logic [1:0]       res_type;
    logic [PC_W-1:0]  res_pc, res_target, res_pred_target, flush_pc;
    logic [CNT_W-1:0] perf_branches, perf_mispredicts;

    branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W),
                       .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_type(res_type),
        .res_is_call(res_is_call), .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .flush(flush), .flush_pc(flush_pc),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain arrays indexed by pc mod table size, RAS as a bounded queue
    int          m_bht [64];
    bit          m_vld [64];
    logic [7:0]  m_tag [64];
    logic [31:0] m_tgt [64];
    logic [1:0]  m_typ [64];
    logic [31:0] m_ras [$];
    int          m_br, m_mp;
    bit          e_pv, e_pt, e_fl;
    logic [31:0] e_ptg, e_fpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_bht[i] = 1;
            m_vld[i] = 1'b0;
        end
        m_ras.delete();
        m_br = 0; m_mp = 0;
        e_pv = 0; e_pt = 0; e_fl = 0; e_ptg = 0; e_fpc = 0;
    endtask

    task automatic cycle(input bit r, input bit fv, input logic [31:0] fpc,
                         input bit rv, input logic [1:0] rt, input bit call, input bit tk,
                         input logic [31:0] rpc, input logic [31:0] rtg,
                         input bit ptk, input logic [31:0] ptg);
        bit act, mp;
        int fi, ri;
        rst = r; fetch_valid = fv; fetch_pc = fpc;
        res_valid = rv; res_type = rt; res_is_call = call; res_taken = tk;
        res_pc = rpc; res_target = rtg; res_pred_taken = ptk; res_pred_target = ptg;
        act = rv && (rt != 2'b00);
        mp  = act && ((tk != ptk) || (tk && (rtg != ptg)));
        if (r) begin
            model_reset();
        end else begin
            e_pv = fv && !mp;
            if (fv) begin
                fi    = int'(fpc % 64);
                e_pt  = 0;
                e_ptg = fpc + 1;
                if (m_vld[fi] && m_tag[fi] == 8'((fpc / 64) % 256)) begin
                    if (m_typ[fi] == 2'd1 && m_bht[fi] >= 2) begin
                        e_pt = 1; e_ptg = m_tgt[fi];
                    end else if (m_typ[fi] == 2'd2) begin
                        e_pt = 1; e_ptg = m_tgt[fi];
                    end else if (m_typ[fi] == 2'd3 && m_ras.size() > 0) begin
                        e_pt = 1; e_ptg = m_ras[$];
                    end
                end
            end
            e_fl = mp;
            if (mp) e_fpc = tk ? rtg : rpc + 1;
            if (act) begin
                ri = int'(rpc % 64);
                m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
                if (mp) m_mp = (m_mp < CMAX) ? m_mp + 1 : CMAX;
                if (rt == 2'd1) m_bht[ri] = tk ? ((m_bht[ri] < 3) ? m_bht[ri] + 1 : 3)
                                               : ((m_bht[ri] > 0) ? m_bht[ri] - 1 : 0);
                if (tk) begin
                    m_vld[ri] = 1'b1;
                    m_tag[ri] = 8'((rpc / 64) % 256);
                    m_tgt[ri] = rtg;
                    m_typ[ri] = rt;
                end
                if (call) begin
                    m_ras.push_back(rpc + 1);
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                end else if (rt == 2'd3 && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end
        @(posedge clk);
        #1;
        chk("pred_valid", 32'(pred_valid), 32'(e_pv));
        chk("pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("pred_target", pred_target, e_ptg);
        chk("flush", 32'(flush), 32'(e_fl));
        chk("flush_pc", flush_pc, e_fpc);
        chk("perf_branches", 32'(perf_branches), m_br);
        chk("perf_mispredicts", 32'(perf_mispredicts), m_mp);
    endtask

    task automatic fetch(input logic [31:0] pc);
        cycle(0, 1, pc, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [1:0] rt, input bit call, input bit tk, input logic [31:0] rpc,
                           input logic [31:0] rtg, input bit ptk, input logic [31:0] ptg);
        cycle(0, 0, 0, 1, rt, call, tk, rpc, rtg, ptk, ptg);
    endtask

    initial begin
        bit          r_b, fv_b, tk_b, call_b, ptk_b, rv_b;
        logic [1:0]  rt_v;
        logic [31:0] fpc_v, rpc_v, rtg_v, ptg_v, exp_t;

        cycle(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        chk("reset_flush", 32'(flush), 0);

        fetch(32'h10);
        chk("t1_valid", 32'(pred_valid), 1);
        chk("t1_target", pred_target, 32'h11);

        resolve(2'd1, 0, 1, 32'h20, 32'h40, 0, 0);
        chk("t2_flush_pc_a", flush_pc, 32'h40);
        resolve(2'd1, 0, 1, 32'h20, 32'h40, 0, 0);
        chk("t2_flush_pc_b", flush_pc, 32'h40);
        fetch(32'h20);
        chk("t2_taken", 32'(pred_taken), 1);
        chk("t2_target", pred_target, 32'h40);

        repeat (5) resolve(2'd1, 0, 0, 32'h20, 0, 0, 0);
        fetch(32'h20);
        chk("t3_taken", 32'(pred_taken), 0);
        chk("t3_target", pred_target, 32'h21);

        resolve(2'd2, 1, 1, 32'h30, 32'h80, 0, 0);
        resolve(2'd3, 0, 1, 32'h90, 32'h31, 0, 0);
        resolve(2'd2, 1, 1, 32'h30, 32'h80, 1, 32'h80);
        fetch(32'h90);
        chk("t4_taken", 32'(pred_taken), 1);
        chk("t4_target", pred_target, 32'h31);

        for (int i = 0; i < 5; i++) resolve(2'd2, 1, 1, 32'h100 + i, 32'h200, 1, 32'h200);
        for (int i = 0; i < 5; i++) begin
            exp_t = (i < 4) ? 32'h105 - i : 32'h91;
            fetch(32'h90);
            chk("t5_taken", 32'(pred_taken), (i < 4) ? 1 : 0);
            chk("t5_target", pred_target, exp_t);
            resolve(2'd3, 0, 1, 32'h90, exp_t, (i < 4), exp_t);
        end

        cycle(0, 1, 32'h50, 1, 2'd1, 0, 0, 32'h50, 32'h60, 1, 32'h60);
        chk("t6_flush", 32'(flush), 1);
        chk("t6_flush_pc", flush_pc, 32'h51);
        chk("t6_pred_valid", 32'(pred_valid), 0);
        // reset in the same cycle as a mispredicting resolve must drop the flush
        cycle(1, 1, 32'h50, 1, 2'd1, 0, 0, 32'h50, 32'h60, 1, 32'h60);
        chk("t6_rst_flush", 32'(flush), 0);
        chk("t6_rst_perf", 32'(perf_branches), 0);

        for (int k = 0; k < 800; k++) begin
            r_b    = ($urandom_range(0, 249) == 0);
            fv_b   = ($urandom_range(0, 3) != 0);
            fpc_v  = 32'h20 + $urandom_range(0, 3) + ($urandom_range(0, 1) << 6);
            rv_b   = ($urandom_range(0, 3) != 0);
            rt_v   = 2'($urandom_range(0, 3));
            rpc_v  = 32'h20 + $urandom_range(0, 3) + ($urandom_range(0, 1) << 6);
            tk_b   = (rt_v >= 2'd2) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            rtg_v  = 32'h300 + $urandom_range(0, 3);
            call_b = (rt_v == 2'd2) && ($urandom_range(0, 1) == 1);
            ptk_b  = ($urandom_range(0, 3) != 0) ? tk_b : !tk_b;
            ptg_v  = ($urandom_range(0, 1) == 1) ? rtg_v : 32'h300 + $urandom_range(0, 3);
            cycle(r_b, fv_b, fpc_v, rv_b, rt_v, call_b, tk_b, rpc_v, rtg_v, ptk_b, ptg_v);
        end
        chk("perf_saturated", 32'(perf_branches), m_br);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
